// File: rtl/fmap_stream_sink.sv
// Feature-map stream sink: captures one CHANNEL x SIZE x SIZE frame in raster order and
// serves it through a registered random-access read port.
module fmap_stream_sink #(
    parameter int unsigned N       = 16,
    parameter int unsigned CHANNEL = 3,
    parameter int unsigned SIZE    = 6,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   input_vld,
    input  logic [CHANNEL*N-1:0]   input_din,
    input  logic                   input_end,
    input  logic                   clear,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [CHANNEL*N-1:0]   rd_dout,
    output logic                   rd_dout_vld,
    output logic                   frame_done,
    output logic [ADDR_W:0]        pixel_count,
    output logic                   err_short,
    output logic                   err_overflow
);

    localparam int unsigned      Words    = SIZE * SIZE;
    localparam int unsigned      W        = CHANNEL * N;
    localparam logic [ADDR_W:0]  WordsCnt = (ADDR_W + 1)'(Words);
    localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(Words - 1);

    typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              short_q, short_d;
    logic              ovf_q, ovf_d;
    logic              mem_we;
    logic              rd_in_range;
    logic [W-1:0]      rd_dout_q;
    logic              rd_vld_q;

    logic [W-1:0] mem [Words];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        short_d  = short_q;
        ovf_d    = ovf_q;
        mem_we   = 1'b0;
        // clear dominates any word presented in the same cycle
        if (clear) begin
            state_d  = StIdle;
            wr_ptr_d = '0;
            count_d  = '0;
            short_d  = 1'b0;
            ovf_d    = 1'b0;
        end else if (ce && input_vld) begin
            if (state_q == StDone) begin
                ovf_d = 1'b1;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                count_d  = count_q + (ADDR_W + 1)'(1);
                state_d  = StCapture;
                if (wr_ptr_q == LastPtr) begin
                    state_d = StDone;
                end else if (input_end) begin
                    state_d = StDone;
                    short_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            count_q  <= '0;
            short_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            short_q  <= short_d;
            ovf_q    <= ovf_d;
        end
    end

    // Buffer is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= input_din;
        end
    end

    assign rd_in_range = {1'b0, rd_addr} < WordsCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dout_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_vld_q <= rd_en;
            if (rd_en) begin
                rd_dout_q <= rd_in_range ? mem[rd_addr] : '0;
            end
        end
    end

    assign rd_dout      = rd_dout_q;
    assign rd_dout_vld  = rd_vld_q;
    assign frame_done   = (state_q == StDone);
    assign pixel_count  = count_q;
    assign err_short    = short_q;
    assign err_overflow = ovf_q;

endmodule

// File: tb/tb_fmap_stream_sink.sv
// Directed bench for fmap_stream_sink with a behavioural frame model and a read scoreboard.
module tb_fmap_stream_sink;

    localparam int AW    = 6;
    localparam int WORDS = 36;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0, input_vld = 1'b0, input_end = 1'b0, clear = 1'b0, rd_en = 1'b0;
    logic [47:0]   input_din = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [47:0]   rd_dout;
    logic          rd_dout_vld, frame_done, err_short, err_overflow;
    logic [AW:0]   pixel_count;

    int          total = 0;
    int          bad = 0;
    logic [47:0] model_mem [WORDS];
    int          m_state, m_ptr;
    logic        m_short, m_ovf;
    logic [47:0] exp_q [$];

    fmap_stream_sink #(.N(16), .CHANNEL(3), .SIZE(6), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .input_vld(input_vld), .input_din(input_din),
        .input_end(input_end), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_dout(rd_dout), .rd_dout_vld(rd_dout_vld), .frame_done(frame_done),
        .pixel_count(pixel_count), .err_short(err_short), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] word(input int k);
        return {16'(k + 2), 16'(k + 1), 16'(k)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic status();
        chk("frame_done", 64'(frame_done), 64'(m_state == 2));
        chk("pixel_count", 64'(pixel_count), 64'(m_ptr));
        chk("err_short", 64'(err_short), 64'(m_short));
        chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
    endtask

    task automatic reset_model();
        m_state = 0;
        m_ptr   = 0;
        m_short = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic step(input logic [47:0] din, input bit vld, c, e, clr, rd, input int raddr);
        input_din = din;
        input_vld = vld;
        ce        = c;
        input_end = e;
        clear     = clr;
        rd_en     = rd;
        rd_addr   = AW'(raddr);
        if (rd) exp_q.push_back(raddr < WORDS ? model_mem[raddr] : 48'd0);
        if (clr) begin
            reset_model();
        end else if (c && vld) begin
            if (m_state == 2) begin
                m_ovf = 1'b1;
            end else begin
                model_mem[m_ptr] = din;
                if (m_ptr == WORDS - 1) m_state = 2;
                else if (e) begin
                    m_state = 2;
                    m_short = 1'b1;
                end else m_state = 1;
                m_ptr++;
            end
        end
        @(negedge clk);
        chk("rd_vld", 64'(rd_dout_vld), 64'(exp_q.size() != 0));
        if (rd_dout_vld && exp_q.size() != 0) chk("rd_data", 64'(rd_dout), 64'(exp_q.pop_front()));
        status();
    endtask

    task automatic idle();
        step('0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int a);
        step('0, 0, 0, 0, 0, 1, a);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_dout"}, 64'(rd_dout), 64'd0);
        chk({tag, "_rd_vld"}, 64'(rd_dout_vld), 64'd0);
        chk({tag, "_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_count"}, 64'(pixel_count), 64'd0);
        chk({tag, "_short"}, 64'(err_short), 64'd0);
        chk({tag, "_ovf"}, 64'(err_overflow), 64'd0);
    endtask

    initial begin
        int k;
        bit v, c;
        reset_model();
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Full frame then back-to-back readback
        for (int i = 0; i < WORDS; i++) step(word(i), 1, 1, i == WORDS - 1, 0, 0, 0);
        for (int a = 0; a < WORDS; a++) rd(a);
        idle();
        chk("rd_hold", 64'(rd_dout), 64'(word(35)));

        // Overflow in DONE leaves memory untouched
        for (int i = 0; i < 3; i++) step(word(100 + i), 1, 1, 0, 0, 0, 0);
        for (int a = 0; a < WORDS; a++) rd(a);

        // Clear beats a simultaneous valid word
        step(word(200), 1, 1, 0, 1, 0, 0);
        chk("clear_count", 64'(pixel_count), 64'd0);

        // Gapped stream, guaranteed to include vld while ce is low
        step(word(0), 1, 0, 0, 0, 0, 0);
        k = 0;
        for (int it = 0; it < 2000 && k < WORDS; it++) begin
            v = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            step(v ? word(k) : 48'd0, v, c, k == WORDS - 1, 0, 0, 0);
            if (v && c) k++;
        end
        chk("gap_all_words", 64'(k), 64'(WORDS));
        for (int a = 0; a < WORDS; a++) rd(a);

        // Short frame, then overflow after it
        step('0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(word(i + 10), 1, 1, i == 19, 0, 0, 0);
        chk("short_count", 64'(pixel_count), 64'd20);
        rd(19);
        step(word(999), 1, 1, 0, 0, 0, 0);
        rd(20);
        rd(36);
        rd(63);
        idle();

        // Asynchronous reset mid-frame
        step('0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(word(i + 50), 1, 1, 0, 0, 0, 0);
        rd(3);
        idle();
        #2 rst = 1'b1;
        #1;
        check_zero("async_rst");
        reset_model();
        @(negedge clk);
        rst = 1'b0;

        // Fresh frame with read-during-write at address 5
        for (int i = 0; i < WORDS; i++)
            step(word(i + 80), 1, 1, i == WORDS - 1, 0, (i == 5) || (i == 6), 5);
        chk("final_count", 64'(pixel_count), 64'd36);
        idle();
        chk("rd_pending", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
